commit_trace_buffer: RTL
========================

# commit_trace_buffer

Synthesizable commit-trace recorder for the pipelined processor that generalises the simulation-only retirement trace. Each cycle it classifies the retiring instruction (register write, load, store-with-update, store, branch/NOP, halt), tags it with a zero-based instruction number and cycle stamp, and queues it in a parametrised FIFO. The FIFO drains through a valid/ready port to an on-chip trace sink or bench scoreboard. It sits beside the writeback stage and taps the same commit signals the register file and data memory see.

## Interface
- DATA_W, 16, width of PC, instruction, register data, memory address/data
- REG_W, 3, width of register select
- DEPTH, 8, FIFO entries; power of two, ≥2
- CNT_W, 32, width of instruction number, cycle count, drop count
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- commit_valid  in  1  an instruction retires this cycle; tie 1 for unpipelined cores
- commit_pc, commit_inst  in  DATA_W  PC and instruction word of the retiring instruction
- reg_write  in  1  register file written
- write_reg  in  REG_W  destination register
- write_data  in  DATA_W  register write data
- mem_read, mem_write  in  1  data memory read / write (write already qualified by enable)
- mem_addr, mem_data  in  DATA_W  memory address / store data
- halt  in  1  retiring instruction is HALT
- tr_valid  out  1  head entry valid
- tr_ready  in  1  sink accepts head entry
- tr_kind  out  3  0 NOP/branch, 1 REG, 2 LD, 3 STU, 4 ST, 5 HALT
- tr_inum, tr_cycle  out  CNT_W  instruction number, cycle stamp
- tr_pc, tr_value, tr_addr, tr_mdata  out  DATA_W  PC, register value, memory address, store data
- tr_reg  out  REG_W  destination register
- halted  out  1  HALT has retired
- done  out  1  halted and FIFO empty
- overflow  out  1  sticky, at least one entry dropped
- drop_count  out  CNT_W  dropped entries
- cycle_count  out  CNT_W  cycles since reset

## Operation
- Classification, priority order: halt→HALT; reg_write&mem_write→STU; reg_write&mem_read→LD; reg_write→REG; mem_write→ST; else NOP.
- Unused fields are pushed as zero: tr_reg/tr_value are zero unless REG/LD/STU; tr_addr is zero unless LD/STU/ST; tr_mdata is zero unless STU/ST.
- A commit is a rising clock edge with commit_valid=1 and halted=0. Each commit:
  - pushes one entry with tr_inum = current inst_num, then increments inst_num;
  - tr_cycle = cycle_count at that edge.
- inst_num advances on dropped commits as well, so a drop shows as a gap in tr_inum.
- Push succeeds if the FIFO is not full, or if it is full and a pop occurs the same cycle (pop frees the slot first).
- Otherwise the entry is dropped, overflow sets (sticky until rst) and drop_count increments. drop_count saturates at all-ones.
- A HALT commit sets halted whether or not its entry is dropped. While halted, commits are ignored: no push, no inum or drop change.
- Pop on tr_valid & tr_ready. tr_ready while empty has no effect.
- cycle_count increments every cycle after reset, wraps modulo 2^CNT_W. inst_num also wraps.
- State: FIFO storage, read/write pointers with one extra wrap bit (full = MSBs differ, low bits equal), inst_num, cycle_count, drop_count, overflow, halted.

## Timing
- All outputs registered or driven from registered state. No combinational path from inputs to tr_* or tr_valid.
- Latency: a commit at edge N into an empty FIFO gives tr_valid=1 with that entry after edge N (visible cycle N+1).
- Throughput: one push and one pop per cycle sustained. A full FIFO with tr_ready held high never drops.
- tr_* must hold stable while tr_valid=1 and tr_ready=0.
- done rises the cycle after the pop that empties the FIFO once halted=1. If HALT is pushed into an empty FIFO, done stays 0 until that HALT entry is popped.
- Reset values:
  - tr_valid, halted, done, overflow: 0;
  - drop_count, cycle_count, inst_num: 0;
  - FIFO empty;
  - tr_* data: 0.
- rst asserted mid-operation discards all entries and clears all state immediately. The first commit after release gets inum 0.

## Test plan
- Single REG commit (pc 0x0002, r3←0x1234) into empty FIFO, tr_ready=1 → next cycle tr_valid=1, kind 1, inum 0, reg 3, value 0x1234, addr 0, mdata 0; popped, FIFO empty.
- STU (reg_write+mem_write, r5←0x0010, addr 0x0010, data 0xBEEF), then LD, then ST → kinds 3, 2, 4 with inum 0, 1, 2 and unused fields zero.
- tr_ready=0, DEPTH=8, 10 consecutive REG commits → 8 entries held, overflow=1, drop_count=2; draining yields inum 0–7.
- FIFO full, simultaneous commit and pop → no drop, overflow stays 0, occupancy stays 8.
- NOP, NOP, HALT, then 3 more commits → entries inum 0, 1, 2 (kind 5 last); later commits ignored; done=1 the cycle after the HALT entry pops.
- rst pulsed with 4 entries queued and halted=1 → all outputs 0 immediately; next commit gets inum 0, cycle stamp restarts.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit-trace recorder: classifies each retiring instruction, stamps it with
// an instruction number and cycle count, and queues it for a valid/ready sink.
module commit_trace_buffer #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    input  logic [DATA_W-1:0] commit_pc,
    input  logic [DATA_W-1:0] commit_inst,
    input  logic              reg_write,
    input  logic [REG_W-1:0]  write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              halt,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [2:0]        tr_kind,
    output logic [CNT_W-1:0]  tr_inum,
    output logic [CNT_W-1:0]  tr_cycle,
    output logic [DATA_W-1:0] tr_pc,
    output logic [DATA_W-1:0] tr_value,
    output logic [DATA_W-1:0] tr_addr,
    output logic [DATA_W-1:0] tr_mdata,
    output logic [REG_W-1:0]  tr_reg,
    output logic              halted,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [2:0] KIND_NOP  = 3'd0;
    localparam logic [2:0] KIND_REG  = 3'd1;
    localparam logic [2:0] KIND_LD   = 3'd2;
    localparam logic [2:0] KIND_STU  = 3'd3;
    localparam logic [2:0] KIND_ST   = 3'd4;
    localparam logic [2:0] KIND_HALT = 3'd5;

    logic [2:0]        kindMem  [DEPTH];
    logic [CNT_W-1:0]  inumMem  [DEPTH];
    logic [CNT_W-1:0]  cycleMem [DEPTH];
    logic [DATA_W-1:0] pcMem    [DEPTH];
    logic [DATA_W-1:0] valueMem [DEPTH];
    logic [DATA_W-1:0] addrMem  [DEPTH];
    logic [DATA_W-1:0] mdataMem [DEPTH];
    logic [REG_W-1:0]  regMem   [DEPTH];

    logic [PW-1:0]     wrPtr, rdPtr;
    logic [CNT_W-1:0]  instNum, cycleCount, dropCount;
    logic              haltedQ, overflowQ;

    logic [2:0]        newKind;
    logic [REG_W-1:0]  newReg;
    logic [DATA_W-1:0] newValue, newAddr, newMdata;
    logic              commit, empty, full, pop, push, drop;
    logic              unusedInst;

    assign unusedInst = ^commit_inst;

    always_comb begin
        newKind = KIND_NOP;
        if (halt)                        newKind = KIND_HALT;
        else if (reg_write && mem_write) newKind = KIND_STU;
        else if (reg_write && mem_read)  newKind = KIND_LD;
        else if (reg_write)              newKind = KIND_REG;
        else if (mem_write)              newKind = KIND_ST;
    end

    // Fields irrelevant to the instruction class are forced to zero.
    always_comb begin
        newReg   = '0;
        newValue = '0;
        newAddr  = '0;
        newMdata = '0;
        if (newKind == KIND_REG || newKind == KIND_LD || newKind == KIND_STU) begin
            newReg   = write_reg;
            newValue = write_data;
        end
        if (newKind == KIND_LD || newKind == KIND_STU || newKind == KIND_ST)
            newAddr = mem_addr;
        if (newKind == KIND_STU || newKind == KIND_ST)
            newMdata = mem_data;
    end

    assign commit = commit_valid && !haltedQ;
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign pop    = !empty && tr_ready;
    assign push   = commit && (!full || pop);
    assign drop   = commit && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            kindMem[wrPtr[AW-1:0]]  <= newKind;
            inumMem[wrPtr[AW-1:0]]  <= instNum;
            cycleMem[wrPtr[AW-1:0]] <= cycleCount;
            pcMem[wrPtr[AW-1:0]]    <= commit_pc;
            valueMem[wrPtr[AW-1:0]] <= newValue;
            addrMem[wrPtr[AW-1:0]]  <= newAddr;
            mdataMem[wrPtr[AW-1:0]] <= newMdata;
            regMem[wrPtr[AW-1:0]]   <= newReg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            instNum    <= '0;
            cycleCount <= '0;
            dropCount  <= '0;
            haltedQ    <= 1'b0;
            overflowQ  <= 1'b0;
        end else begin
            cycleCount <= cycleCount + CNT_W'(1);
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            if (commit) begin
                instNum <= instNum + CNT_W'(1);
                if (halt) haltedQ <= 1'b1;
            end
            if (drop) begin
                overflowQ <= 1'b1;
                if (dropCount != '1) dropCount <= dropCount + CNT_W'(1);
            end
        end
    end

    // Storage is not reset; gating on empty keeps the data outputs zero when idle.
    assign tr_valid    = !empty;
    assign tr_kind     = empty ? '0 : kindMem[rdPtr[AW-1:0]];
    assign tr_inum     = empty ? '0 : inumMem[rdPtr[AW-1:0]];
    assign tr_cycle    = empty ? '0 : cycleMem[rdPtr[AW-1:0]];
    assign tr_pc       = empty ? '0 : pcMem[rdPtr[AW-1:0]];
    assign tr_value    = empty ? '0 : valueMem[rdPtr[AW-1:0]];
    assign tr_addr     = empty ? '0 : addrMem[rdPtr[AW-1:0]];
    assign tr_mdata    = empty ? '0 : mdataMem[rdPtr[AW-1:0]];
    assign tr_reg      = empty ? '0 : regMem[rdPtr[AW-1:0]];
    assign halted      = haltedQ;
    assign done        = haltedQ && empty;
    assign overflow    = overflowQ;
    assign drop_count  = dropCount;
    assign cycle_count = cycleCount;

endmodule
